// File: rtl/mips_cpu_bus_memory_waitstate.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_bus_memory_waitstate
// Description : Word-addressed Avalon-style simulation RAM for the MIPS32 bus
//               CPU. It has a configurable depth, base address and wait-state
//               count, arbitrary byte-lane masks and a real waitrequest
//               handshake.
// Revision    : 1.0 - initial release
//
// Parameters  : RAM_INIT_FILE - hex file loaded at time 0 ("" = all zero)
//               MEM_WORDS     - depth in 32-bit words
//               BASE_ADDR     - byte address of word 0 (word aligned)
//               WAIT_CYCLES   - wait states before every acknowledge (0..15)
// Ports       : clk         - clock, rising edge
//               reset       - synchronous active-high reset
//               read/write  - requests, held by master until acknowledged
//               address     - byte address, bits [1:0] ignored
//               byteenable  - per-lane enable for read and write data
//               writedata   - write data
//               waitrequest - high while the request is not yet accepted
//               readdata    - read data, valid in the acknowledge cycle
// Option      : MIPS_BUS_MEM_RANDOM_STALL_EN - adds 0..3 pseudo-random extra
//               wait states per transaction from a 16-bit LFSR.
// ============================================================================
module mips_cpu_bus_memory_waitstate #(
  parameter string       RAM_INIT_FILE = "",
  parameter int          MEM_WORDS     = 8192,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          WAIT_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata
);

  localparam int          c_AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] c_MEM_WORDS = 32'(MEM_WORDS);
  localparam logic [4:0]  c_WAIT      = 5'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [c_AW-1:0] idx_q, idx_d;
  logic            inr_q, inr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            wr_q, wr_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            w_commit;

  logic [31:0]     mem_q [0:MEM_WORDS-1];

  // Address decode of the live request (used only while IDLE).
  logic [31:0]     w_offset;
  logic [31:0]     w_word_off;
  logic            w_in_range;
  logic            w_unused;

  assign w_offset   = address - BASE_ADDR;
  assign w_word_off = {2'b00, w_offset[31:2]};
  assign w_in_range = (address >= BASE_ADDR) && (w_word_off < c_MEM_WORDS);
  assign w_unused   = ^w_offset[1:0];

  // Total stall for the transaction being accepted.
  logic [4:0] w_stall;

`ifdef MIPS_BUS_MEM_RANDOM_STALL_EN
  logic [15:0] lfsr_q;
  logic        w_fb;

  // Fibonacci LFSR, taps 16,14,13,11.
  assign w_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign w_stall = c_WAIT + {3'b000, lfsr_q[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], w_fb};
    end
  end
`else
  assign w_stall = c_WAIT;
`endif

  // Read path: when ACK is entered directly from IDLE the latched copies are
  // not yet valid, so the live request is used instead.
  logic [c_AW-1:0] w_acc_idx;
  logic            w_acc_inr;
  logic [3:0]      w_acc_be;
  logic [31:0]     w_mem_word;
  logic [31:0]     w_rmask;
  logic [31:0]     w_read_val;

  assign w_acc_idx  = (state_q == S_IDLE) ? w_word_off[c_AW-1:0] : idx_q;
  assign w_acc_inr  = (state_q == S_IDLE) ? w_in_range : inr_q;
  assign w_acc_be   = (state_q == S_IDLE) ? byteenable : be_q;
  assign w_mem_word = mem_q[w_acc_idx];

  always_comb begin
    w_rmask = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (w_acc_be[i]) begin
        w_rmask[8*i +: 8] = w_mem_word[8*i +: 8];
      end
    end
  end

  assign w_read_val = w_acc_inr ? w_rmask : 32'h0;

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    inr_d    = inr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    rdata_d  = rdata_q;
    w_commit = 1'b0;

    case (state_q)
      S_IDLE: begin
        // read and write together is illegal and ignored.
        if (read ^ write) begin
          idx_d   = w_word_off[c_AW-1:0];
          inr_d   = w_in_range;
          be_d    = byteenable;
          wdata_d = writedata;
          wr_d    = write;
          if (w_stall == 5'd0) begin
            state_d = S_ACK;
            if (!write) begin
              rdata_d = w_read_val;
            end
          end else begin
            state_d = S_WAIT;
            cnt_d   = w_stall - 5'd1;
          end
        end
      end
      S_WAIT: begin
        if (!read && !write) begin
          // Master withdrew its request: abandon without touching storage.
          state_d = S_IDLE;
        end else if (cnt_q == 5'd0) begin
          state_d = S_ACK;
          if (!wr_q) begin
            rdata_d = w_read_val;
          end
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_ACK: begin
        state_d  = S_IDLE;
        w_commit = wr_q && inr_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      idx_q   <= '0;
      inr_q   <= 1'b0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      wr_q    <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      inr_q   <= inr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is never cleared by reset; a write caught by reset in ACK is
  // discarded rather than committed.
  always_ff @(posedge clk) begin
    if (!reset && w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign waitrequest = (state_q != S_ACK);
  assign readdata    = rdata_q;

`ifndef SYNTHESIS
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem_q[i] = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && (state_q == S_IDLE) && read && write) begin
      $display("WARNING: %m read and write both asserted at %0t, request ignored", $time);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_bus_memory_waitstate.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_cpu_bus_memory_waitstate
// Description : Self-checking bench for mips_cpu_bus_memory_waitstate.
//               dut 0: defaults (WAIT_CYCLES=1, base 0, 8192 words)
//               dut 1: base 0xBFC00000, 16 words, WAIT_CYCLES=3
//               dut 2: 64 words, WAIT_CYCLES=0
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_bus_memory_waitstate;

  logic        clk;
  logic        rst   [3];
  logic        rd_r  [3];
  logic        wr_r  [3];
  logic [31:0] addr_r[3];
  logic [3:0]  be_r  [3];
  logic [31:0] wd_r  [3];
  logic        wq    [3];
  logic [31:0] rq    [3];

  int n_chk = 0;
  int n_bad = 0;

  logic [31:0] model_b[16];
  logic [31:0] model_c[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mips_cpu_bus_memory_waitstate #(.WAIT_CYCLES(1)) dut_a (
    .clk(clk), .reset(rst[0]), .read(rd_r[0]), .write(wr_r[0]),
    .address(addr_r[0]), .byteenable(be_r[0]), .writedata(wd_r[0]),
    .waitrequest(wq[0]), .readdata(rq[0])
  );

  mips_cpu_bus_memory_waitstate #(
    .MEM_WORDS(16), .BASE_ADDR(32'hBFC0_0000), .WAIT_CYCLES(3)
  ) dut_b (
    .clk(clk), .reset(rst[1]), .read(rd_r[1]), .write(wr_r[1]),
    .address(addr_r[1]), .byteenable(be_r[1]), .writedata(wd_r[1]),
    .waitrequest(wq[1]), .readdata(rq[1])
  );

  mips_cpu_bus_memory_waitstate #(.MEM_WORDS(64), .WAIT_CYCLES(0)) dut_c (
    .clk(clk), .reset(rst[2]), .read(rd_r[2]), .write(wr_r[2]),
    .address(addr_r[2]), .byteenable(be_r[2]), .writedata(wd_r[2]),
    .waitrequest(wq[2]), .readdata(rq[2])
  );

  typedef struct {
    int          d;
    bit          w;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          chk;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Fixed latency normally; with random stalls anything from exp to exp+3.
  task automatic chk_lat(input string nm, input int lat, input int exp);
    bit ok;
`ifdef MIPS_BUS_MEM_RANDOM_STALL_EN
    ok = (lat >= exp) && (lat <= exp + 3);
`else
    ok = (lat == exp);
`endif
    n_chk++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s latency: got %0d expected %0d", nm, lat, exp);
    end
  endtask

  // One complete transaction. lat = cycles from the cycle the request is
  // first seen to the cycle waitrequest is low (-1 on timeout).
  task automatic do_op(input int d, input bit w, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd,
                       output int lat, output logic [31:0] rdv);
    @(posedge clk); #1;
    addr_r[d] = a; be_r[d] = be; wd_r[d] = wd;
    rd_r[d] = !w; wr_r[d] = w;
    lat = -1;
    rdv = 32'hxxxx_xxxx;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (!wq[d]) begin
        lat = k;
        rdv = rq[d];
        break;
      end
    end
    rd_r[d] = 1'b0; wr_r[d] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rdv;
    bit          seen[5];
    bit          low_seen;

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; rd_r[d] = 1'b0; wr_r[d] = 1'b0;
      addr_r[d] = 32'h0; be_r[d] = 4'h0; wd_r[d] = 32'h0;
    end
    for (int i = 0; i < 16; i++) model_b[i] = 32'h0;
    for (int i = 0; i < 5; i++) seen[i] = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_wq[%0d]", d), {31'b0, wq[d]}, 32'h1);
      chk($sformatf("reset_rd[%0d]", d), rq[d], 32'h0);
    end
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    @(posedge clk); @(negedge clk);
    for (int d = 0; d < 3; d++)
      chk($sformatf("idle_wq[%0d]", d), {31'b0, wq[d]}, 32'h1);

    // ---------------- vector table ----------------
    vt.push_back('{0, 1, 32'h10,   4'hF, 32'hDEADBEEF, 0, 32'h0,        2});
    vt.push_back('{0, 0, 32'h10,   4'hF, 32'h0,        1, 32'hDEADBEEF, 2});
    vt.push_back('{0, 1, 32'h20,   4'hF, 32'h11223344, 0, 32'h0,        2});
    vt.push_back('{0, 1, 32'h20,   4'h5, 32'hAABBCCDD, 0, 32'h0,        2});
    vt.push_back('{0, 0, 32'h20,   4'hF, 32'h0,        1, 32'h11BB33DD, 2});
    vt.push_back('{0, 0, 32'h20,   4'h2, 32'h0,        1, 32'h00003300, 2});
    vt.push_back('{0, 0, 32'h20,   4'h0, 32'h0,        1, 32'h00000000, 2});
    vt.push_back('{0, 1, 32'h20,   4'h0, 32'hFFFFFFFF, 0, 32'h0,        2});
    vt.push_back('{0, 0, 32'h20,   4'hF, 32'h0,        1, 32'h11BB33DD, 2});
    vt.push_back('{0, 1, 32'h24,   4'h9, 32'h12345678, 0, 32'h0,        2});
    vt.push_back('{0, 0, 32'h24,   4'hF, 32'h0,        1, 32'h12000078, 2});
    vt.push_back('{0, 1, 32'h7FFC, 4'hF, 32'hCAFEF00D, 0, 32'h0,        2});
    vt.push_back('{0, 0, 32'h7FFC, 4'hF, 32'h0,        1, 32'hCAFEF00D, 2});
    vt.push_back('{0, 1, 32'h8000, 4'hF, 32'h55555555, 0, 32'h0,        2});
    vt.push_back('{0, 0, 32'h0,    4'hF, 32'h0,        1, 32'h00000000, 2});
    vt.push_back('{0, 0, 32'h8000, 4'hF, 32'h0,        1, 32'h00000000, 2});
    vt.push_back('{0, 0, 32'h13,   4'hF, 32'h0,        1, 32'hDEADBEEF, 2});
    vt.push_back('{1, 1, 32'hBFC00000, 4'hF, 32'hA5A5A5A5, 0, 32'h0,        4});
    vt.push_back('{1, 1, 32'hBFC0003C, 4'hF, 32'h0BADF00D, 0, 32'h0,        4});
    vt.push_back('{1, 1, 32'hBFBFFFFC, 4'hF, 32'hFFFFFFFF, 0, 32'h0,        4});
    vt.push_back('{1, 0, 32'hBFC0003C, 4'hF, 32'h0,        1, 32'h0BADF00D, 4});
    vt.push_back('{1, 0, 32'hBFC00040, 4'hF, 32'h0,        1, 32'h00000000, 4});
    vt.push_back('{1, 0, 32'hBFC00000, 4'hF, 32'h0,        1, 32'hA5A5A5A5, 4});
    model_b[0]  = 32'hA5A5A5A5;
    model_b[15] = 32'h0BADF00D;

    foreach (vt[i]) begin
      do_op(vt[i].d, vt[i].w, vt[i].a, vt[i].be, vt[i].wd, lat, rdv);
      chk_lat($sformatf("vec%0d", i), lat, vt[i].lat);
      if (vt[i].chk) chk($sformatf("vec%0d_data", i), rdv, vt[i].exp);
    end

    // ---------------- readdata holds across a write ----------------
    do_op(1, 1'b1, 32'hBFC00008, 4'hF, 32'h77777777, lat, rdv);
    chk("rd_hold", rdv, 32'hA5A5A5A5);
    model_b[2] = 32'h77777777;

    // ---------------- reset during 2nd WAIT cycle: read ----------------
    @(posedge clk); #1;
    addr_r[1] = 32'hBFC00000; be_r[1] = 4'hF; rd_r[1] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0; rd_r[1] = 1'b0;
    @(negedge clk);
    chk("rstabort_wq", {31'b0, wq[1]}, 32'h1);
    chk("rstabort_rd", rq[1], 32'h0);
    chk("rstabort_state", 32'(dut_b.state_q), 32'h0);

    // ---------------- reset during 2nd WAIT cycle: write ----------------
    @(posedge clk); #1;
    addr_r[1] = 32'hBFC00004; be_r[1] = 4'hF; wd_r[1] = 32'h12121212; wr_r[1] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0; wr_r[1] = 1'b0;

    // ---------------- request withdrawn during WAIT ----------------
    @(posedge clk); #1;
    addr_r[1] = 32'hBFC00008; be_r[1] = 4'hF; wd_r[1] = 32'hEEEEEEEE; wr_r[1] = 1'b1;
    @(posedge clk); #1;
    wr_r[1] = 1'b0;
    low_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (!wq[1]) low_seen = 1'b1;
    end
    chk("withdraw_wq", {31'b0, low_seen}, 32'h0);

    for (int i = 0; i < 16; i++)
      chk($sformatf("dumpB[%0d]", i), dut_b.mem_q[i], model_b[i]);

    // ---------------- read and write together ----------------
    @(posedge clk); #1;
    addr_r[0] = 32'h30; be_r[0] = 4'hF; wd_r[0] = 32'h99999999;
    rd_r[0] = 1'b1; wr_r[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("illegal_wq%0d", k), {31'b0, wq[0]}, 32'h1);
    end
    rd_r[0] = 1'b0; wr_r[0] = 1'b0;
    chk("illegal_mem", dut_a.mem_q[12], 32'h0);
    do_op(0, 1'b0, 32'h30, 4'hF, 32'h0, lat, rdv);
    chk("illegal_read", rdv, 32'h0);

    // ---------------- zero wait states ----------------
    for (int i = 0; i < 8; i++) begin
      model_c[i] = (32'h01010101 * i) ^ 32'hA5000000;
      do_op(2, 1'b1, 32'(i * 4), 4'hF, model_c[i], lat, rdv);
      chk_lat($sformatf("c_wr%0d", i), lat, 1);
    end
`ifdef MIPS_BUS_MEM_RANDOM_STALL_EN
    for (int n = 0; n < 100; n++) begin
      int idx;
      idx = $urandom_range(0, 7);
      do_op(2, 1'b0, 32'(idx * 4), 4'hF, 32'h0, lat, rdv);
      chk_lat($sformatf("c_rnd%0d", n), lat, 1);
      chk($sformatf("c_rnd%0d_data", n), rdv, model_c[idx]);
      if (lat >= 1 && lat <= 4) seen[lat] = 1'b1;
    end
    for (int l = 1; l <= 4; l++)
      chk($sformatf("c_lat%0d_seen", l), {31'b0, seen[l]}, 32'h1);
`else
    for (int i = 0; i < 8; i++) begin
      do_op(2, 1'b0, 32'(i * 4), 4'hF, 32'h0, lat, rdv);
      chk_lat($sformatf("c_rd%0d", i), lat, 1);
      chk($sformatf("c_rd%0d_data", i), rdv, model_c[i]);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
